// File: rtl/ring_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ring_decoder_pkg
//  Purpose  : Definitions shared by the ring-code sources and ring_decoder:
//             the decoder FSM state encoding, the default ring width, the
//             rotation-direction encoding and a counter sizing helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ring_decoder_pkg;

  // Decoder FSM states. The encoding is shared with the ring-code sources.
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Rotation direction: forward is a left rotate, reverse is a right rotate.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_t;

  // Default ring length in bits.
  localparam int RING_W_DEF = 4;

  // Bits needed to hold values 0..lock_cnt inclusive.
  function automatic int run_width(input int lock_cnt);
    return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_decoder_onehot_idx.sv
`default_nettype none
// ============================================================================
//  Module   : ring_onehot_idx
//  Purpose  : Purely combinational one-hot checker and binary encoder.
//  Ports    : code      [WIDTH-1:0] in  - ring code to examine
//             idx       [IW-1:0]    out - index of the set bit (valid only
//                                         when is_onehot is 1)
//             is_onehot             out - exactly one bit of code is set
//  Revision : 1.0 - initial release
// ============================================================================
module ring_onehot_idx
  import ring_decoder_pkg::*;
#(
  parameter  int WIDTH = RING_W_DEF,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    idx,
  output logic             is_onehot
);

  // OR-ing the indices of all set bits gives the exact index for a one-hot
  // code; for any other code the result is don't-care and is_onehot is 0.
  always_comb begin
    idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (code[k]) begin
        idx = idx | IW'(k);
      end
    end
  end

  // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
  assign is_onehot = (code != '0) && ((code & (code - WIDTH'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/ring_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ring_decoder
//  Purpose  : Samples a one-hot ring code, converts it to a binary index,
//             checks that it is legal and advances in rotation order, locks
//             after LOCK_CNT consecutive correct successions and counts full
//             revolutions while locked. All outputs are registered with one
//             clock of latency from the sampling edge.
//  Ports    : clk          in  - system clock, rising edge
//             rst          in  - asynchronous reset, active low
//             in_valid     in  - ring_in is sampled when 1
//             ring_in      in  - one-hot ring code [WIDTH-1:0]
//             idx_out      out - index of the last legal sample [IW-1:0]
//             idx_valid    out - pulse: idx_out updated this cycle
//             locked       out - level: FSM in LOCK
//             err_illegal  out - pulse: sample was not one-hot
//             err_seq      out - pulse: legal but out-of-order sample in LOCK
//             lap_cnt      out - completed revolutions, wraps [LAP_W-1:0]
//             lap_pulse    out - pulse on each revolution
//             dir          out - lock direction, 0 fwd / 1 rev
//                                (only with RING_DIR_DETECT_EN)
//  Options  : `define RING_DIR_DETECT_EN to accept rotation in either
//             direction; the direction of the acquiring run is locked in.
//  Revision : 1.0 - initial release
// ============================================================================
module ring_decoder
  import ring_decoder_pkg::*;
#(
  parameter  int WIDTH    = RING_W_DEF,
  parameter  int LOCK_CNT = 3,
  parameter  int LAP_W    = 8,
  localparam int IW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IW-1:0]    idx_out,
  output logic             idx_valid,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             lap_pulse
`ifdef RING_DIR_DETECT_EN
  ,
  output logic             dir
`endif
);

  localparam int            RW         = run_width(LOCK_CNT);
  localparam logic [RW-1:0] RUN_TARGET = RW'(LOCK_CNT);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             prev_ok;
  logic [RW-1:0]    run;

  logic [IW-1:0]    idx;
  logic             is_onehot;

  ring_onehot_idx #(
    .WIDTH (WIDTH)
  ) u_onehot_idx (
    .code      (ring_in),
    .idx       (idx),
    .is_onehot (is_onehot)
  );

  // A legal successor can only be recognised once a legal previous sample
  // exists, so every step qualifier includes prev_ok.
  logic [WIDTH-1:0] succ_fwd;
  logic             step_fwd;
  assign succ_fwd = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign step_fwd = prev_ok && (ring_in == succ_fwd);

  logic             hunt_step;  // sample extends the acquisition run
  logic [RW-1:0]    run_next;   // run length including this sample
  logic             lock_ok;    // sample is the expected successor in LOCK
  logic             lap_hit;    // that successor completes a revolution

`ifdef RING_DIR_DETECT_EN
  logic [WIDTH-1:0] succ_rev;
  logic             step_rev;
  dir_t             cand;
  dir_t             step_dir;

  assign succ_rev = {prev[0], prev[WIDTH-1:1]};
  assign step_rev = prev_ok && (ring_in == succ_rev);

  always_comb begin
    hunt_step = step_fwd | step_rev;
    // With WIDTH = 2 both directions match; keep the candidate so the run
    // keeps growing instead of restarting.
    if (step_fwd && step_rev) begin
      step_dir = cand;
    end else if (step_rev) begin
      step_dir = DIR_REV;
    end else begin
      step_dir = DIR_FWD;
    end
    // A step against the current candidate restarts the run at one.
    if ((run != '0) && (step_dir != cand)) begin
      run_next = RW'(1);
    end else begin
      run_next = run + RW'(1);
    end
    lock_ok = (dir == DIR_REV) ? step_rev : step_fwd;
    // Reverse laps close on the 0 -> WIDTH-1 step, forward on WIDTH-1 -> 0.
    lap_hit = (dir == DIR_REV) ? (idx == IW'(WIDTH - 1)) : (idx == '0);
  end
`else
  always_comb begin
    hunt_step = step_fwd;
    run_next  = run + RW'(1);
    lock_ok   = step_fwd;
    // The forward successor lands on index 0 only when leaving WIDTH-1.
    lap_hit   = (idx == '0);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HUNT;
      prev        <= '0;
      prev_ok     <= 1'b0;
      run         <= '0;
      idx_out     <= '0;
      idx_valid   <= 1'b0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      lap_cnt     <= '0;
      lap_pulse   <= 1'b0;
`ifdef RING_DIR_DETECT_EN
      cand        <= DIR_FWD;
      dir         <= 1'b0;
`endif
    end else begin
      idx_valid   <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      lap_pulse   <= 1'b0;

      if (in_valid) begin
        if (!is_onehot) begin
          // idx_out and prev are left alone; only the succession history
          // is discarded.
          err_illegal <= 1'b1;
          state       <= ST_HUNT;
          locked      <= 1'b0;
          prev_ok     <= 1'b0;
          run         <= '0;
        end else begin
          idx_valid <= 1'b1;
          idx_out   <= idx;
          prev      <= ring_in;
          prev_ok   <= 1'b1;

          case (state)
            ST_HUNT: begin
              if (hunt_step) begin
                if (run_next == RUN_TARGET) begin
                  // The locking step never counts as a lap.
                  state  <= ST_LOCK;
                  locked <= 1'b1;
                  run    <= '0;
`ifdef RING_DIR_DETECT_EN
                  dir    <= step_dir;
`endif
                end else begin
                  run <= run_next;
                end
`ifdef RING_DIR_DETECT_EN
                cand <= step_dir;
`endif
              end else begin
                run <= '0;
              end
            end
            ST_LOCK: begin
              if (lock_ok) begin
                if (lap_hit) begin
                  lap_cnt   <= lap_cnt + LAP_W'(1);
                  lap_pulse <= 1'b1;
                end
              end else begin
                // prev already takes this sample above, so re-acquisition
                // starts from it.
                err_seq <= 1'b1;
                state   <= ST_HUNT;
                locked  <= 1'b0;
                run     <= '0;
              end
            end
            default: begin
              state  <= ST_HUNT;
              locked <= 1'b0;
              run    <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_decoder
//  Purpose  : Self-checking bench for ring_decoder (WIDTH=4, LOCK_CNT=3,
//             LAP_W=8). A behavioural index-arithmetic model predicts every
//             output on every clock; directed sequences add literal checks.
//             Honours RING_DIR_DETECT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_decoder;

  localparam int W  = 4;
  localparam int LC = 3;
  localparam int LW = 8;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  ring_in  = '0;
  logic [1:0]    idx_out;
  logic          idx_valid;
  logic          locked;
  logic          err_illegal;
  logic          err_seq;
  logic [LW-1:0] lap_cnt;
  logic          lap_pulse;
`ifdef RING_DIR_DETECT_EN
  logic          dir;
`endif

  int n_vec = 0;
  int n_err = 0;

  ring_decoder #(
    .WIDTH    (W),
    .LOCK_CNT (LC),
    .LAP_W    (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .ring_in     (ring_in),
    .idx_out     (idx_out),
    .idx_valid   (idx_valid),
    .locked      (locked),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .lap_cnt     (lap_cnt),
    .lap_pulse   (lap_pulse)
`ifdef RING_DIR_DETECT_EN
    ,
    .dir         (dir)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (indices, not codes) ----------------
  bit m_locked, m_prev_ok, m_dir, m_cand;
  int m_prev, m_run, m_idx, m_lap;
  bit e_iv, e_ill, e_seq, e_lp;

  task automatic model_step(input bit r, input bit v, input logic [W-1:0] c);
    int  k;
    bit  fwd, rev, sd;
    e_iv = 0; e_ill = 0; e_seq = 0; e_lp = 0;
    if (!r) begin
      m_locked = 0; m_prev_ok = 0; m_prev = 0; m_run = 0;
      m_idx = 0; m_lap = 0; m_dir = 0; m_cand = 0;
      return;
    end
    if (!v) return;
    if ($countones(c) != 1) begin
      e_ill = 1; m_locked = 0; m_prev_ok = 0; m_run = 0;
      return;
    end
    k = 0;
    for (int i = 0; i < W; i++) if (c[i]) k = i;
    e_iv  = 1;
    m_idx = k;
    fwd = m_prev_ok && (k == (m_prev + 1) % W);
`ifdef RING_DIR_DETECT_EN
    rev = m_prev_ok && (k == (m_prev + W - 1) % W);
`else
    rev = 0;
`endif
    if (!m_locked) begin
      if (fwd || rev) begin
        sd = rev;
        if (m_run > 0 && sd != m_cand) m_run = 1;
        else m_run = m_run + 1;
        m_cand = sd;
        if (m_run == LC) begin
          m_locked = 1; m_run = 0; m_dir = sd;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (m_dir ? rev : fwd) begin
        if (m_dir ? (k == W - 1) : (k == 0)) begin
          e_lp  = 1;
          m_lap = (m_lap + 1) % (1 << LW);
        end
      end else begin
        e_seq = 1; m_locked = 0; m_run = 0;
      end
    end
    m_prev    = k;
    m_prev_ok = 1;
  endtask

  // ---------------- compare process: every clock ----------------
  always @(posedge clk) begin
    model_step(rst, in_valid, ring_in);
    #1;
    check("idx_out",     idx_out,     m_idx);
    check("idx_valid",   idx_valid,   e_iv);
    check("locked",      locked,      m_locked);
    check("err_illegal", err_illegal, e_ill);
    check("err_seq",     err_seq,     e_seq);
    check("lap_cnt",     lap_cnt,     m_lap);
    check("lap_pulse",   lap_pulse,   e_lp);
`ifdef RING_DIR_DETECT_EN
    check("dir",         dir,         m_dir);
`endif
  end

  // Apply one sample; returns 2 time units after the sampling edge.
  task automatic drive(input bit v, input logic [W-1:0] c);
    @(negedge clk);
    in_valid = v;
    ring_in  = c;
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus and literal checks ----------------
  initial begin
    logic [W-1:0] last;
    logic [W-1:0] nc;
    int           r;
    bit           v;

    // Reset state
    @(posedge clk);
    #2;
    check("rst_idx_out", idx_out, 0);
    check("rst_locked",  locked,  0);
    check("rst_lap_cnt", lap_cnt, 0);
    check("rst_idx_vld", idx_valid, 0);
    @(negedge clk);
    rst = 1'b1;

    // Acquire: lock rises on the edge sampling 1000
    drive(1, 4'b0001); check("acq0_idx", idx_out, 0); check("acq0_vld", idx_valid, 1);
    drive(1, 4'b0010); check("acq1_idx", idx_out, 1);
    drive(1, 4'b0100); check("acq2_idx", idx_out, 2); check("acq2_lock", locked, 0);
    drive(1, 4'b1000); check("acq3_idx", idx_out, 3); check("acq3_lock", locked, 1);

    // First lap, then 256 more -> wraps back to 1
    drive(1, 4'b0001); check("lap1_pulse", lap_pulse, 1); check("lap1_cnt", lap_cnt, 1);
    drive(0, 4'b0000); check("lap1_pulse_end", lap_pulse, 0);
    for (int n = 0; n < 256; n++) begin
      drive(1, 4'b0010); drive(1, 4'b0100); drive(1, 4'b1000); drive(1, 4'b0001);
    end
    check("lap_wrap_cnt", lap_cnt, 1);

    // Illegal code while locked at 0010
    drive(1, 4'b0010);
    drive(1, 4'b0011);
    check("ill_pulse", err_illegal, 1); check("ill_lock", locked, 0);
    check("ill_idx", idx_out, 1);       check("ill_vld", idx_valid, 0);
    drive(1, 4'b0100); check("ill_next_vld", idx_valid, 1); check("ill_next_lock", locked, 0);

    // Relock, then out-of-order code while locked at 0100
    drive(1, 4'b1000); drive(1, 4'b0001); drive(1, 4'b0010);
    check("relock1", locked, 1);
    drive(1, 4'b0100);
    drive(1, 4'b0001);
    check("seq_pulse", err_seq, 1); check("seq_lock", locked, 0); check("seq_idx", idx_out, 0);
    drive(1, 4'b0010); drive(1, 4'b0100); drive(1, 4'b1000);
    check("relock2", locked, 1);

    // Gaps in in_valid are ignored
    drive(1, 4'b0001);
    drive(0, 4'b1111);
    drive(0, 4'b1111);
    drive(1, 4'b0010);
    check("gap_lock", locked, 1); check("gap_idx", idx_out, 1); check("gap_lap", lap_cnt, 2);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_idx",  idx_out, 0);
    check("arst_lock", locked,  0);
    check("arst_lap",  lap_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Randomised traffic, mostly well-ordered so that lock is reached often
    last = 4'b0001;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      nc = {last[W-2:0], last[W-1]};
      else if (r < 78) nc = {last[0], last[W-1:1]};
      else if (r < 86) nc = last;
      else             nc = W'($urandom);
      v = ($urandom_range(0, 4) != 0);
      if (v && $countones(nc) == 1) last = nc;
      drive(v, nc);
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

`ifdef RING_DIR_DETECT_EN
    // Reverse rotation locks with dir = 1 and laps on 0 -> 3
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 4'b1000); drive(1, 4'b0100); drive(1, 4'b0010); drive(1, 4'b0001);
    check("rev_lock", locked, 1); check("rev_dir", dir, 1);
    drive(1, 4'b1000);
    check("rev_lap_pulse", lap_pulse, 1); check("rev_lap_cnt", lap_cnt, 1);
`endif

    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_decoder.md
Name: ring_decoder

Overview:
Receiving end of the ring-counter interface: samples a WIDTH-bit one-hot ring code and converts it to a binary index. It also checks that the code is legal one-hot and advances in rotation order, locks after a run of correct steps, and counts full revolutions. It sits downstream of ringCnt-style sources, for example in self-check logic or a cross-block status monitor.

Parameters:
WIDTH, 4, ring length in bits; must be >= 2.
LOCK_CNT, 3, consecutive correct successions required to enter LOCK; must be >= 1.
LAP_W, 8, width of the revolution counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
in_valid  input  1  ring_in is sampled on clocks where this is 1.
ring_in  input  WIDTH  one-hot ring code.
idx_out  output  IW = $clog2(WIDTH)  binary index of the last legal sample.
idx_valid  output  1  1-cycle pulse: idx_out updated this cycle.
locked  output  1  level: FSM in LOCK.
err_illegal  output  1  1-cycle pulse: sampled code not one-hot.
err_seq  output  1  1-cycle pulse: legal code, but not the expected successor while in LOCK.
lap_cnt  output  LAP_W  number of completed revolutions.
lap_pulse  output  1  1-cycle pulse on each revolution.

Behaviour:
- Forward rotation is a left rotate by one bit. For WIDTH=4: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- Successor(p) = {p[WIDTH-2:0], p[WIDTH-1]}.
- Bit k set means index k.
- All outputs are registered. Latency is 1 clock from the sampling edge.
- Reset (rst = 0, asynchronous):
  - state = HUNT, prev = 0, prev_ok = 0, run = 0.
  - idx_out = 0, lap_cnt = 0.
  - All pulse outputs = 0, locked = 0.
- in_valid = 0: no state change; all pulses 0; idx_out, locked and lap_cnt hold.
- Illegal sample (zero bits or more than one bit set), in any state:
  - err_illegal = 1 and idx_valid = 0.
  - state -> HUNT, prev_ok = 0, run = 0.
  - idx_out holds.
- Legal sample, common actions: idx_valid = 1, idx_out = index, prev = sample, prev_ok = 1.
- HUNT with a legal sample:
  - If prev_ok = 1 and sample = Successor(prev): run += 1. If run reaches LOCK_CNT, state -> LOCK and run = 0.
  - Otherwise run = 0. No err_seq is raised in HUNT.
- LOCK with a legal sample:
  - Sample = Successor(prev): stay in LOCK. If the index steps from WIDTH-1 to 0, lap_cnt += 1 and lap_pulse = 1.
  - Any other legal sample, including a repeat of prev: err_seq = 1, state -> HUNT, run = 0. prev takes the new sample, so re-acquisition starts from it.
- locked = 1 exactly while state = LOCK. It updates on the same edge as the transition.
- lap_cnt:
  - Wraps modulo 2^LAP_W.
  - Holds on loss of lock; cleared only by reset.
  - No lap is counted on the step that enters LOCK.
- Reset asserted mid-operation clears everything immediately. The first sample after release starts HUNT with prev_ok = 0.

Optional Feature:
RING_DIR_DETECT_EN
- Defined:
  - Adds output dir (1 bit, reset 0; 0 = forward/left, 1 = reverse/right).
  - HUNT accepts a succession in either direction. The direction of the first accepted step sets a candidate direction; a step in the opposite direction restarts run at 1 with the new candidate.
  - On entry to LOCK, dir = candidate, and LOCK expects only that direction.
  - In reverse, a lap is the index step 0 -> WIDTH-1.
- Undefined: forward only as described above; no dir port.

Decomposition:
- Shared definitions file ring_defs.vh, used by ringCnt and this block:
  - State encodings: ST_HUNT = 1'b0, ST_LOCK = 1'b1.
  - Default ring width constant RING_W_DEF = 4.
  - Rotate-left and rotate-right macros.
- One sub-module, ring_onehot_idx, purely combinational:
  - Input: WIDTH-bit code.
  - Outputs: IW-bit index and an is_onehot flag.
  - Instantiated once.

Test Plan (WIDTH = 4, LOCK_CNT = 3, LAP_W = 8):
- Reset then 0001, 0010, 0100, 1000 with in_valid = 1 every cycle -> idx_out 0,1,2,3 at 1-cycle latency; locked rises on the edge that samples 1000; no errors.
- Locked, then 0001 -> lap_pulse = 1 for one cycle, lap_cnt = 1. Run 256 more laps -> lap_cnt wraps to 1.
- Locked at prev = 0010, inject 0011 -> err_illegal pulse, locked = 0, idx_out holds 1. Then 0100 -> idx_valid = 1 and no lock.
- Locked at prev = 0100, inject 0001 -> err_seq pulse, locked = 0, idx_out = 0. Then 0010, 0100, 1000 -> relock.
- in_valid toggled 1,0,0,1 during a correct sequence -> gaps ignored, lock is kept; assert rst low mid-sequence -> all outputs 0 asynchronously, before the next clk edge.
- With RING_DIR_DETECT_EN defined: feed 1000, 0100, 0010, 0001 -> locked with dir = 1; then 1000 -> lap_pulse = 1.
